// File: rtl/hpm_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hpm_counter_ctrl
// Brief    : CSR front-end and event gating for a bank of 64-bit hardware
//            performance counters. Optional overflow interrupt is built when
//            HPM_CTRL_OVF_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hpm_counter_ctrl #(
    parameter int NumCounters  = 2,
    parameter int CounterWidth = 32,
    parameter int IdxW         = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         csr_req_i,
    output logic                         csr_gnt_o,
    input  logic                         csr_we_i,
    input  logic                         csr_inh_i,
    input  logic [IdxW-1:0]              csr_idx_i,
    input  logic                         csr_hi_i,
    input  logic [31:0]                  csr_wdata_i,
    output logic                         csr_rvalid_o,
    output logic [31:0]                  csr_rdata_o,
    output logic                         csr_err_o,
    input  logic [NumCounters-1:0]       event_i,
    output logic [NumCounters-1:0]       counter_inc_o,
    output logic [NumCounters-1:0]       counter_we_o,
    output logic [NumCounters-1:0]       counterh_we_o,
    output logic [31:0]                  counter_wdata_o,
    input  logic [NumCounters-1:0][63:0] counter_val_i,
    output logic                         irq_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]             r_state;
    logic                   r_we;
    logic                   r_inh;
    logic                   r_hi;
    logic                   r_err;
    logic [IdxW-1:0]        r_idx;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic [NumCounters-1:0] r_inhibit;

    logic [NumCounters-1:0] w_sel;
    logic                   w_idx_ok;
    logic                   w_cnt_wr;
    logic [63:0]            w_val;
    logic [31:0]            w_rd_next;

    // One-hot decode of the latched index; all zero for out-of-range indices.
    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_sel
        assign w_sel[gi] = (r_idx == IdxW'(gi));
    end

    assign w_idx_ok = |w_sel;
    assign w_cnt_wr = (r_state == c_ACCESS) & r_we & ~r_inh;

    always_comb begin
        w_val = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (w_sel[i]) w_val = w_val | counter_val_i[i];
        end
    end

    always_comb begin
        w_rd_next = '0;
        if (!r_we) begin
            if (r_inh) begin
                w_rd_next[NumCounters-1:0] = r_inhibit;
            end else if (w_idx_ok) begin
                w_rd_next = r_hi ? w_val[63:32] : w_val[31:0];
            end
        end
    end

    assign csr_gnt_o       = (r_state == c_IDLE) & csr_req_i;
    assign csr_rvalid_o    = (r_state == c_RESP);
    assign csr_err_o       = (r_state == c_RESP) & r_err;
    assign csr_rdata_o     = r_rdata;
    assign counter_wdata_o = r_wdata;
    assign counter_we_o    = {NumCounters{w_cnt_wr & ~r_hi}} & w_sel;
    assign counterh_we_o   = {NumCounters{w_cnt_wr &  r_hi}} & w_sel;
    // A software write owns the counter for its strobe cycle, so drop the event.
    assign counter_inc_o   = event_i & ~r_inhibit & ~({NumCounters{w_cnt_wr}} & w_sel);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_IDLE;
            r_we      <= 1'b0;
            r_inh     <= 1'b0;
            r_hi      <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_inhibit <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (csr_req_i) begin
                        r_we    <= csr_we_i;
                        r_inh   <= csr_inh_i;
                        r_idx   <= csr_idx_i;
                        r_hi    <= csr_hi_i;
                        r_wdata <= csr_wdata_i;
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_rdata <= w_rd_next;
                    r_err   <= ~r_inh & ~w_idx_ok;
                    if (r_we && r_inh) r_inhibit <= r_wdata[NumCounters-1:0];
                    r_state <= c_RESP;
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef HPM_CTRL_OVF_IRQ_EN
    logic [NumCounters-1:0] r_ovf;
    logic [NumCounters-1:0] w_wrap;

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_wrap
        assign w_wrap[gi] = &counter_val_i[gi][CounterWidth-1:0];
    end

    // Clear beats set: a rewritten counter starts with a clean overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf | (counter_inc_o & w_wrap)) & ~(counter_we_o | counterh_we_o);
        end
    end

    assign irq_o = |r_ovf;
`else
    logic w_unused_cw;
    assign w_unused_cw = (CounterWidth > 0);
    assign irq_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpm_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpm_counter_ctrl
// Brief    : Directed plus randomized bench for hpm_counter_ctrl against a
//            cycle-indexed transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpm_counter_ctrl;
    localparam int NC = 3;
    localparam int CW = 10;
    localparam int IW = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                csr_req_i = 1'b0;
    logic                csr_gnt_o;
    logic                csr_we_i = 1'b0;
    logic                csr_inh_i = 1'b0;
    logic [IW-1:0]       csr_idx_i = '0;
    logic                csr_hi_i = 1'b0;
    logic [31:0]         csr_wdata_i = '0;
    logic                csr_rvalid_o;
    logic [31:0]         csr_rdata_o;
    logic                csr_err_o;
    logic [NC-1:0]       event_i = '0;
    logic [NC-1:0]       counter_inc_o;
    logic [NC-1:0]       counter_we_o;
    logic [NC-1:0]       counterh_we_o;
    logic [31:0]         counter_wdata_o;
    logic [NC-1:0][63:0] counter_val_i = '0;
    logic                irq_o;

    hpm_counter_ctrl #(.NumCounters(NC), .CounterWidth(CW), .IdxW(IW)) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .csr_req_i      (csr_req_i),
        .csr_gnt_o      (csr_gnt_o),
        .csr_we_i       (csr_we_i),
        .csr_inh_i      (csr_inh_i),
        .csr_idx_i      (csr_idx_i),
        .csr_hi_i       (csr_hi_i),
        .csr_wdata_i    (csr_wdata_i),
        .csr_rvalid_o   (csr_rvalid_o),
        .csr_rdata_o    (csr_rdata_o),
        .csr_err_o      (csr_err_o),
        .event_i        (event_i),
        .counter_inc_o  (counter_inc_o),
        .counter_we_o   (counter_we_o),
        .counterh_we_o  (counterh_we_o),
        .counter_wdata_o(counter_wdata_o),
        .counter_val_i  (counter_val_i),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    logic          active = 1'b0;
    int            t_T = 0;
    logic          t_we, t_inh, t_hi;
    logic [IW-1:0] t_idx;
    logic [31:0]   t_wdata;
    logic [NC-1:0] m_inh = '0;
    logic [NC-1:0] m_ovf = '0;
    logic [31:0]   m_rdata = '0;
    logic [31:0]   m_wdata = '0;

    always @(negedge clk_i) begin
        logic          is_acc, is_resp, valid, e_gnt;
        logic [NC-1:0] sel, e_we, e_hwe, e_inc, wrap;
        if (!rst_ni) begin
            active  = 1'b0;
            m_inh   = '0;
            m_ovf   = '0;
            m_rdata = '0;
            m_wdata = '0;
        end else begin
            is_acc  = active && (cyc == t_T + 1);
            is_resp = active && (cyc == t_T + 2);
            e_gnt   = csr_req_i && !(active && cyc <= t_T + 2);
            valid   = t_inh || (int'(t_idx) < NC);
            sel = '0;
            for (int i = 0; i < NC; i++) if (int'(t_idx) == i) sel[i] = 1'b1;
            e_we  = (is_acc && t_we && !t_inh && !t_hi) ? sel : '0;
            e_hwe = (is_acc && t_we && !t_inh &&  t_hi) ? sel : '0;
            e_inc = event_i & ~m_inh & ~((is_acc && t_we && !t_inh) ? sel : '0);
            for (int i = 0; i < NC; i++) wrap[i] = (counter_val_i[i][CW-1:0] == {CW{1'b1}});

            chk("gnt",    csr_gnt_o,       e_gnt);
            chk("we",     counter_we_o,    e_we);
            chk("hwe",    counterh_we_o,   e_hwe);
            chk("wdata",  counter_wdata_o, m_wdata);
            chk("inc",    counter_inc_o,   e_inc);
            chk("rvalid", csr_rvalid_o,    is_resp);
            chk("rdata",  csr_rdata_o,     m_rdata);
            if (is_resp) chk("err", csr_err_o, !valid);
`ifdef HPM_CTRL_OVF_IRQ_EN
            chk("irq", irq_o, |m_ovf);
            m_ovf = (m_ovf | (e_inc & wrap)) & ~(e_we | e_hwe);
`else
            chk("irq", irq_o, 1'b0);
`endif
            if (is_acc) begin
                if (t_we || !valid) m_rdata = '0;
                else if (t_inh)     m_rdata = 32'(m_inh);
                else                m_rdata = t_hi ? counter_val_i[t_idx][63:32]
                                               : counter_val_i[t_idx][31:0];
                if (t_we && t_inh) m_inh = t_wdata[NC-1:0];
            end
            if (e_gnt) begin
                active  = 1'b1;
                t_T     = cyc;
                t_we    = csr_we_i;
                t_inh   = csr_inh_i;
                t_idx   = csr_idx_i;
                t_hi    = csr_hi_i;
                t_wdata = csr_wdata_i;
                m_wdata = csr_wdata_i;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic inh, input logic [IW-1:0] idx,
                       input logic hi, input logic [31:0] wd);
        csr_req_i = 1'b1; csr_we_i = we; csr_inh_i = inh;
        csr_idx_i = idx;  csr_hi_i = hi; csr_wdata_i = wd;
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_gnt",    csr_gnt_o,       1'b0);
        chk("rst_rvalid", csr_rvalid_o,    1'b0);
        chk("rst_rdata",  csr_rdata_o,     32'h0);
        chk("rst_wdata",  counter_wdata_o, 32'h0);
        chk("rst_strobe", {counter_we_o, counterh_we_o}, '0);
        chk("rst_irq",    irq_o,           1'b0);
        step(); rst_ni = 1'b1;

        // counter write: strobe at T+1, response at T+2
        step(); req(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_00AA);
        @(negedge clk_i); chk("t1_gnt", csr_gnt_o, 1'b1);
        step(); csr_req_i = 1'b0;
        @(negedge clk_i); chk("t1_we", counter_we_o, 3'b010); chk("t1_wd", counter_wdata_o, 32'hAA);
        step();
        @(negedge clk_i); chk("t1_rv", csr_rvalid_o, 1'b1); chk("t1_err", csr_err_o, 1'b0);
        chk("t1_rd", csr_rdata_o, 32'h0);

        // high-half read with req held
        step(); counter_val_i[0] = 64'h1234_5678_9ABC_DEF0; req(1'b0, 1'b0, 2'd0, 1'b1, 32'h0);
        step();
        @(negedge clk_i); chk("t2_gnt1", csr_gnt_o, 1'b0);
        step();
        @(negedge clk_i); chk("t2_gnt2", csr_gnt_o, 1'b0); chk("t2_rv", csr_rvalid_o, 1'b1);
        chk("t2_rd", csr_rdata_o, 32'h1234_5678);

        // inhibit write: gating applies from T+2
        step(); event_i = 3'b011; req(1'b1, 1'b1, 2'd0, 1'b0, 32'h1);
        @(negedge clk_i); chk("t3_inc0", counter_inc_o, 3'b011);
        step(); csr_req_i = 1'b0;
        @(negedge clk_i); chk("t3_inc1", counter_inc_o, 3'b011);
        step();
        @(negedge clk_i); chk("t3_inc2", counter_inc_o, 3'b010);
        step(); req(1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
        step(); csr_req_i = 1'b0;
        step();
        @(negedge clk_i); chk("t3_inhrd", csr_rdata_o, 32'h1);

        // out-of-range index
        step(); req(1'b1, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFF);
        step(); csr_req_i = 1'b0;
        @(negedge clk_i); chk("t4_str", {counter_we_o, counterh_we_o}, '0);
        step();
        @(negedge clk_i); chk("t4_rv", csr_rvalid_o, 1'b1); chk("t4_err", csr_err_o, 1'b1);
        chk("t4_rd", csr_rdata_o, 32'h0);

        // async reset during ACCESS of a read
        step(); req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
        step(); csr_req_i = 1'b0; rst_ni = 1'b0;
        @(negedge clk_i); chk("t5_rv1", csr_rvalid_o, 1'b0);
        step();
        @(negedge clk_i); chk("t5_rv2", csr_rvalid_o, 1'b0);
        step(); rst_ni = 1'b1;
        @(negedge clk_i); chk("t5_inh", counter_inc_o, 3'b011);

        // write wins over a same-cycle event
        step(); event_i = 3'b001; req(1'b1, 1'b0, 2'd0, 1'b1, 32'h5);
        step(); csr_req_i = 1'b0;
        @(negedge clk_i); chk("t5_inc_drop", counter_inc_o, 3'b000);
        step();
        @(negedge clk_i); chk("t5_inc_back", counter_inc_o, 3'b001);

        // overflow interrupt
        step(); event_i = 3'b010; counter_val_i[1] = 64'h0000_0000_0000_03FF;
        step(); event_i = 3'b000; counter_val_i[1] = 64'h0;
`ifdef HPM_CTRL_OVF_IRQ_EN
        @(negedge clk_i); chk("t6_irq_set", irq_o, 1'b1);
        step(); req(1'b1, 1'b0, 2'd1, 1'b0, 32'h0);
        step(); csr_req_i = 1'b0;
        @(negedge clk_i); chk("t6_irq_hold", irq_o, 1'b1);
        step();
        @(negedge clk_i); chk("t6_irq_clr", irq_o, 1'b0);
`else
        @(negedge clk_i); chk("t6_irq_off", irq_o, 1'b0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            rst_ni      = ($urandom_range(0, 499) != 0);
            csr_req_i   = $urandom_range(0, 1);
            csr_we_i    = $urandom_range(0, 1);
            csr_inh_i   = ($urandom_range(0, 3) == 0);
            csr_idx_i   = IW'($urandom_range(0, 3));
            csr_hi_i    = $urandom_range(0, 1);
            csr_wdata_i = $urandom;
            event_i     = NC'($urandom);
            for (int i = 0; i < NC; i++) begin
                counter_val_i[i] = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) counter_val_i[i][CW-1:0] = {CW{1'b1}};
            end
        end
        step(); rst_ni = 1'b1; csr_req_i = 1'b0;
        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hpm_counter_ctrl.md
Name: hpm_counter_ctrl

Overview:
Controller and CSR front-end for a bank of NumCounters 64-bit performance counters (counter_inc/counter_we/counterh_we/counter_val_i/counter_val_o interface).
Serialises CSR read/write requests onto the shared bank, gates per-counter events through an inhibit register, and optionally raises an overflow interrupt.
Sits between the CSR file and the counter instances in the generate loop.

Parameters:
NumCounters, 2, number of counters controlled (1..32)
CounterWidth, 32, implemented counter width (1..64); sets the overflow point
IdxW, $clog2(NumCounters) min 1, derived; width of counter index

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
csr_req_i  in  1  CSR access request
csr_gnt_o  out  1  request accepted this cycle
csr_we_i  in  1  1=write, 0=read
csr_inh_i  in  1  access targets inhibit register (idx/hi ignored)
csr_idx_i  in  IdxW  counter index
csr_hi_i  in  1  select upper 32 bits
csr_wdata_i  in  32  write data
csr_rvalid_o  out  1  response valid, one-cycle pulse
csr_rdata_o  out  32  read data
csr_err_o  out  1  error, qualified by csr_rvalid_o
event_i  in  NumCounters  per-counter increment event
counter_inc_o  out  NumCounters  to counter_inc_i of each counter
counter_we_o  out  NumCounters  low-half write strobe
counterh_we_o  out  NumCounters  high-half write strobe
counter_wdata_o  out  32  shared write data to all counters
counter_val_i  in  NumCounters x 64  counter values
irq_o  out  1  overflow interrupt

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE.
- Inhibit register resets to all 0 (all counters counting).

FSM states IDLE, ACCESS, RESP:
- IDLE: csr_gnt_o = csr_req_i, combinational. On grant (cycle T), latch we/inh/idx/hi/wdata and go to ACCESS.
- ACCESS (T+1), write to counter: assert exactly one of counter_we_o[idx] (hi=0) or counterh_we_o[idx] (hi=1) for one cycle. counter_wdata_o = latched wdata (held stable in all states, reset 0).
- ACCESS (T+1), write to inhibit: update inhibit[NumCounters-1:0] from wdata at the end of ACCESS.
- ACCESS (T+1), read: register csr_rdata_o from counter_val_i[idx] bits [63:32] or [31:0], or from the zero-extended inhibit register.
- RESP (T+2): csr_rvalid_o = 1 for one cycle, then return to IDLE.
- csr_rdata_o is 0 for writes and errors; it holds its value until the next RESP.
- csr_gnt_o = 0 in ACCESS and RESP. Latency is request to rvalid = 2 cycles; throughput is 1 access per 3 cycles.

Errors and event gating:
- idx >= NumCounters (non-inhibit access): no strobes, rdata 0, csr_err_o = 1 in RESP.
- counter_inc_o[i] = event_i[i] & ~inhibit[i] & ~(ACCESS & write & !inh & idx==i). Combinational. Increments are suppressed during the write-strobe cycle.
- An inhibit write takes effect on counter_inc_o from T+2.

Boundary conditions:
- Write and event to the same counter in the same cycle: the write wins and the event is dropped.
- Read of a counter while it is incrementing: returns the value present in the ACCESS cycle. A 64-bit read is two independent accesses; no atomic snapshot.
- Async reset mid-transaction: return to IDLE, no rvalid, no strobe, inhibit cleared.
- csr_req_i deasserted in ACCESS/RESP has no effect; the transaction completes.

Optional Feature:
HPM_CTRL_OVF_IRQ_EN:
- Defined:
  - Sticky ovf[i] sets when counter_inc_o[i]=1 and counter_val_i[i][CounterWidth-1:0] is all ones (wrap to 0).
  - ovf[i] clears on any write strobe to counter i. If set and clear coincide, clear wins.
  - irq_o registered = |ovf, so it rises 1 cycle after the wrapping increment.
- Undefined: no ovf state; irq_o tied 0; port retained.

Test Plan:
1. Write idx=1 hi=0 wdata=0x0000_00AA: counter_we_o=2'b10 exactly at T+1, counter_wdata_o=0xAA, rvalid at T+2 with err=0 and rdata=0.
2. Read idx=0 hi=1 with counter_val_i[0]=0x1234_5678_9ABC_DEF0: rvalid at T+2 with rdata=0x1234_5678; csr_gnt_o=0 at T+1 and T+2 despite req held.
3. event_i=2'b11, inhibit write wdata=0x1: counter_inc_o=2'b11 up to T+1, 2'b10 from T+2; inhibit readback returns 0x0000_0001.
4. idx=3 with NumCounters=2: no strobes, rvalid at T+2, err=1, rdata=0.
5. event_i[0]=1 during a write ACCESS to idx 0: counter_inc_o[0]=0 that cycle and 1 the cycle after. rst_ni low at T+1 of a read: no rvalid, inhibit=0.
6. HPM_CTRL_OVF_IRQ_EN, CounterWidth=10, counter_val_i[0][9:0]=0x3FF, event: irq_o=1 next cycle; write idx0 clears it after strobe; undefined build: irq_o stays 0.
